// File: rtl/uart_pkg.sv
// Shared UART definitions: queued byte width and the transmit-feeder FSM states.
package uart_pkg;

   localparam int BYTE_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO. Occupancy is tracked in count; full and empty
// are registered copies derived from the next count value, so they always
// agree with count. Storage is not reset; only pointers and flags are.
module uart_sync_fifo #(
   parameter int WIDTH = uart_pkg::BYTE_WIDTH,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_next_s;
   logic             full_r;
   logic             empty_r;
   logic             overflow_r;
   logic             push_s;
   logic             pop_s;

   // Qualify push/pop (a full FIFO refuses writes even if a pop happens the same cycle) and compute next occupancy.
   always_comb begin
      push_s       = wr_en & ~full_r & ~clr;
      pop_s        = rd_en & ~empty_r & ~clr;
      count_next_s = count_r;
      if (clr) begin
         count_next_s = ZERO_C;
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
         endcase
      end
   end

   // Pointer advance; DEPTH is a power of two so the pointers wrap from DEPTH-1 to 0 naturally.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else if (clr) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy, status flags and the dropped-write pulse (a write flushed by clr is not an overflow).
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count_r    <= ZERO_C;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         count_r    <= count_next_s;
         full_r     <= (count_next_s == DEPTH_C);
         empty_r    <= (count_next_s == ZERO_C);
         overflow_r <= wr_en & full_r & ~clr;
      end
   end

   // Storage write; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign rd_data  = mem_r[rd_ptr_r];
   assign full     = full_r;
   assign empty    = empty_r;
   assign count    = count_r;
   assign overflow = overflow_r;

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds queued bytes to a UART transmitter one at a time: pops the FIFO head
// into tx_data, pulses tx_start, then waits for a rising edge of tx_done.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int BYTE_WIDTH = uart_pkg::BYTE_WIDTH,
   parameter int DEPTH      = 16
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     wr_en,
   input  logic [BYTE_WIDTH-1:0]    wr_data,
   input  logic                     clr,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     tx_start,
   output logic [BYTE_WIDTH-1:0]    tx_data,
   input  logic                     tx_done,
   output logic                     busy
);

   tx_state_e              state_r;
   tx_state_e              state_next_s;
   logic                   pop_s;
   logic                   tx_rise_s;
   logic                   done_q_r;
   logic                   tx_start_r;
   logic                   busy_r;
   logic [BYTE_WIDTH-1:0]  tx_data_r;
   logic [BYTE_WIDTH-1:0]  fifo_rd_data_s;
   logic                   fifo_empty_s;

   uart_sync_fifo #(
      .WIDTH (BYTE_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .arst_n   (arst_n),
      .clr      (clr),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop_s),
      .rd_data  (fifo_rd_data_s),
      .full     (full),
      .empty    (fifo_empty_s),
      .count    (count),
      .overflow (overflow)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a completion edge only counts while waiting for it.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s && !clr) begin
               state_next_s = START;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            state_next_s = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_rise_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT_DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Decoded controls: FIFO pop on leaving IDLE, and tx_done rising-edge detect.
   always_comb begin
      pop_s     = 1'b0;
      tx_rise_s = tx_done & ~done_q_r;
      case (state_r)
         IDLE:    pop_s = ~fifo_empty_s & ~clr;
         default: pop_s = 1'b0;
      endcase
   end

   // Registered transmitter-facing outputs; tx_data is only loaded on a pop so it holds through the transfer.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         done_q_r   <= 1'b0;
         tx_start_r <= 1'b0;
         busy_r     <= 1'b0;
         tx_data_r  <= {BYTE_WIDTH{1'b0}};
      end else begin
         done_q_r   <= tx_done;
         tx_start_r <= (state_r == START);
         busy_r     <= (state_next_s != IDLE);
         if (pop_s) begin
            tx_data_r <= fifo_rd_data_s;
         end
      end
   end

   assign empty    = fifo_empty_s;
   assign tx_start = tx_start_r;
   assign tx_data  = tx_data_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: expected bytes are queued when written,
// and each tx_start pops and compares the next one. A small transmitter model
// answers each tx_start with a tx_done pulse of configurable latency/width.
module tb_uart_tx_feeder;

   localparam int BW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          arst_n;
   logic          wr_en;
   logic [BW-1:0] wr_data;
   logic          clr;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          tx_start;
   logic [BW-1:0] tx_data;
   logic          tx_done;
   logic          busy;

   int            checks    = 0;
   int            failures  = 0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] exp_b;
   int            start_cnt = 0;
   int            pending   = 0;
   int            done_lat  = 2;
   int            done_hold = 1;
   bit            prev_start = 1'b0;
   int            base;

   uart_tx_feeder #(.BYTE_WIDTH(BW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clr      (clr),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Set inputs for one clock, return at the following falling edge.
   task automatic drive(input bit we, input logic [BW-1:0] d, input bit c);
      wr_en   = we;
      wr_data = d;
      clr     = c;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while ((busy || !empty) && n < max_cycles) begin
         drive(1'b0, 8'h00, 1'b0);
         n++;
      end
      check_eq("idle_within_bound", 32'(!busy && empty), 32'd1);
   endtask

   // Start monitor: scoreboard compare on every tx_start and one-cycle width check.
   initial begin
      forever begin
         @(negedge clk);
         if (prev_start) check_eq("tx_start_one_cycle", 32'(tx_start), 32'd0);
         if (tx_start && !prev_start) begin
            start_cnt++;
            pending++;
            check_eq("sb_has_entry_at_start", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               exp_b = exp_q.pop_front();
               check_eq("tx_data_order", 32'(tx_data), 32'(exp_b));
            end
         end
         prev_start = tx_start;
      end
   end

   // Transmitter model: answers each start with a tx_done pulse.
   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (pending > 0) begin
            repeat (done_lat) @(negedge clk);
            tx_done = 1'b1;
            repeat (done_hold) @(negedge clk);
            tx_done = 1'b0;
            pending--;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      arst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_empty",    32'(empty),    32'd1);
      check_eq("rst_full",     32'(full),     32'd0);
      check_eq("rst_count",    32'(count),    32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_tx_start", 32'(tx_start), 32'd0);
      check_eq("rst_tx_data",  32'(tx_data),  32'd0);
      check_eq("rst_busy",     32'(busy),     32'd0);
      arst_n = 1'b1;
      @(negedge clk);

      // Single byte into an idle, empty feeder: start pulse two edges after the write.
      exp_q.push_back(8'hA5);
      drive(1'b1, 8'hA5, 1'b0);
      check_eq("a5_count_after_write", 32'(count), 32'd1);
      check_eq("a5_empty_after_write", 32'(empty), 32'd0);
      drive(1'b0, 8'h00, 1'b0);
      check_eq("a5_no_start_yet", 32'(tx_start), 32'd0);
      check_eq("a5_busy_in_start", 32'(busy), 32'd1);
      check_eq("a5_count_after_pop", 32'(count), 32'd0);
      drive(1'b0, 8'h00, 1'b0);
      check_eq("a5_start_pulse", 32'(tx_start), 32'd1);
      check_eq("a5_tx_data", 32'(tx_data), 32'hA5);
      wait_idle(100);
      check_eq("a5_sb_drained", 32'(exp_q.size()), 32'd0);

      // Burst to full while the feeder is stuck on a long transfer, then overflow.
      done_lat = 40;
      exp_q.push_back(8'h00);
      drive(1'b1, 8'h00, 1'b0);
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      check_eq("burst_busy_on_first", 32'(busy), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         exp_q.push_back(8'(i));
         drive(1'b1, 8'(i), 1'b0);
      end
      check_eq("burst_count_peak", 32'(count), 32'(DEPTH));
      check_eq("burst_full", 32'(full), 32'd1);
      check_eq("burst_not_empty", 32'(empty), 32'd0);
      drive(1'b1, 8'hFF, 1'b0);
      check_eq("ovf_pulse", 32'(overflow), 32'd1);
      check_eq("ovf_count_held", 32'(count), 32'(DEPTH));
      check_eq("ovf_full_held", 32'(full), 32'd1);
      drive(1'b0, 8'h00, 1'b0);
      check_eq("ovf_pulse_ends", 32'(overflow), 32'd0);
      check_eq("ovf_count_still", 32'(count), 32'(DEPTH));
      done_lat = 2;
      wait_idle(1000);
      check_eq("burst_sb_drained", 32'(exp_q.size()), 32'd0);

      // Flush during WAIT_DONE: 0x11 finishes, 0x22/0x33 are never started.
      done_lat = 20;
      base = start_cnt;
      exp_q.push_back(8'h11);
      drive(1'b1, 8'h11, 1'b0);
      check_eq("clr_count_1", 32'(count), 32'd1);
      drive(1'b1, 8'h22, 1'b0);
      check_eq("clr_count_push_pop", 32'(count), 32'd1);
      drive(1'b1, 8'h33, 1'b0);
      check_eq("clr_count_2", 32'(count), 32'd2);
      repeat (2) drive(1'b0, 8'h00, 1'b0);
      check_eq("clr_busy_before", 32'(busy), 32'd1);
      check_eq("clr_tx_data_held", 32'(tx_data), 32'h11);
      drive(1'b1, 8'h44, 1'b1);
      check_eq("clr_count_zero", 32'(count), 32'd0);
      check_eq("clr_empty", 32'(empty), 32'd1);
      check_eq("clr_write_no_ovf", 32'(overflow), 32'd0);
      check_eq("clr_busy_kept", 32'(busy), 32'd1);
      check_eq("clr_tx_data_kept", 32'(tx_data), 32'h11);
      drive(1'b0, 8'h00, 1'b0);
      check_eq("clr_no_ovf_later", 32'(overflow), 32'd0);
      check_eq("clr_write_discarded", 32'(count), 32'd0);
      wait_idle(200);
      repeat (10) drive(1'b0, 8'h00, 1'b0);
      check_eq("clr_one_start_only", 32'(start_cnt - base), 32'd1);
      check_eq("clr_sb_drained", 32'(exp_q.size()), 32'd0);

      // tx_done held high for 3 cycles: each byte still starts exactly once.
      done_lat  = 2;
      done_hold = 3;
      base = start_cnt;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h5B);
      drive(1'b1, 8'h5A, 1'b0);
      drive(1'b1, 8'h5B, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      wait_idle(200);
      repeat (8) drive(1'b0, 8'h00, 1'b0);
      check_eq("hold_start_count", 32'(start_cnt - base), 32'd2);
      check_eq("hold_count_zero", 32'(count), 32'd0);
      check_eq("hold_sb_drained", 32'(exp_q.size()), 32'd0);
      done_hold = 1;

      // Reset during WAIT_DONE with 4 bytes queued.
      done_lat = 50;
      base = start_cnt;
      exp_q.push_back(8'h70);
      for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h70 + i), 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      check_eq("rst2_count_4", 32'(count), 32'd4);
      check_eq("rst2_busy", 32'(busy), 32'd1);
      arst_n = 1'b0;
      #1;
      check_eq("rst2_empty",    32'(empty),    32'd1);
      check_eq("rst2_full",     32'(full),     32'd0);
      check_eq("rst2_count",    32'(count),    32'd0);
      check_eq("rst2_overflow", 32'(overflow), 32'd0);
      check_eq("rst2_tx_start", 32'(tx_start), 32'd0);
      check_eq("rst2_tx_data",  32'(tx_data),  32'd0);
      check_eq("rst2_busy_low", 32'(busy),     32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      repeat (70) drive(1'b0, 8'h00, 1'b0);
      check_eq("rst2_no_new_start", 32'(start_cnt - base), 32'd1);
      check_eq("rst2_still_empty", 32'(empty), 32'd1);
      check_eq("rst2_idle", 32'(busy), 32'd0);
      check_eq("final_sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, default 8, meaning width of each queued byte.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port arst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_en  input  1  write strobe; pushes wr_data when the FIFO is not full.
REQ-006 SHALL have port wr_data  input  BYTE_WIDTH  byte to queue.
REQ-007 SHALL have port clr  input  1  synchronous flush of queued, not-yet-started bytes.
REQ-008 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-009 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-012 SHALL have port tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-013 SHALL have port tx_data  output  BYTE_WIDTH  byte presented to the transmitter data_in.
REQ-014 SHALL have port tx_done  input  1  transmitter completion; only its rising edge is used.
REQ-015 SHALL have port busy  output  1  high from the START state until the completion edge is seen.

Function
REQ-016 SHALL implement the FIFO as a circular buffer with wr_ptr and rd_ptr that wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a write only when wr_en=1 and full=0; wr_en=1 with full=1 drops the byte and pulses overflow in the next cycle. A pop in the same cycle does not free space for that write.
REQ-018 SHALL leave count unchanged on a simultaneous accepted write and pop.
REQ-019 SHALL use FSM states IDLE, START and WAIT_DONE.
REQ-020 SHALL, in IDLE with empty=0 and clr=0, pop the head entry into the tx_data register and go to START.
REQ-021 SHALL assert tx_start for exactly one cycle while in START, then go to WAIT_DONE.
REQ-022 SHALL stay in WAIT_DONE until a rising edge of tx_done is detected (registered tx_done=0 and current tx_done=1), then go to IDLE.
REQ-023 SHALL hold tx_data stable from START through WAIT_DONE.
REQ-024 SHALL deliver a byte written into an empty FIFO while in IDLE with tx_start high in the cycle after the second rising edge following the write edge (write at edge N, pop at edge N+1, tx_start high during N+2..N+3).
REQ-025 SHALL re-enter START for the next queued byte no earlier than one IDLE cycle after the completion edge.
REQ-026 SHALL empty the FIFO (pointers and count to 0) on clr=1 without affecting START or WAIT_DONE. A write in the same cycle as clr is discarded without an overflow pulse.
REQ-027 SHALL ignore a tx_done rising edge that arrives in IDLE or START.
REQ-028 SHALL derive full and empty from count, not from pointer comparison alone.

Reset
REQ-029 SHALL, on arst_n low, set state=IDLE, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, busy=0, and the tx_done edge register=0, without waiting for clk.
REQ-030 SHALL, on reset during WAIT_DONE, abandon the byte in flight and leave no queued entries.
REQ-031 SHALL leave the FIFO storage array unreset; contents are don't-care.

Structure
REQ-032 SHALL take BYTE_WIDTH and the FSM state enum (IDLE, START, WAIT_DONE) from the shared package uart_pkg.
REQ-033 SHALL contain one sub-module, uart_sync_fifo, holding storage, pointers, count, full and empty; uart_tx_feeder adds the FSM and edge detect.
REQ-034 SHALL connect tx_start, tx_data and tx_done directly to uart_top tx_start, data_in and tx_done without glue logic.

Verification
REQ-035 SHALL cover this case: write 0xA5 to an idle, empty feeder -> tx_start pulses once 2 edges later, tx_data=0xA5, and receiver data_out=0xA5 at rx_done.
REQ-036 SHALL cover this case: burst-write 0x01..0x10 back-to-back -> full=1 after the 16th write with 1 already popped accounted for, count=DEPTH at peak, and bytes leave in order 0x01..0x10.
REQ-037 SHALL cover this case: while full, write 0xFF -> overflow pulses exactly 1 cycle, count unchanged, and 0xFF never transmitted.
REQ-038 SHALL cover this case: queue 0x11,0x22,0x33 then assert clr during WAIT_DONE of 0x11 -> 0x11 completes and 0x22 and 0x33 are never started.
REQ-039 SHALL cover this case: hold tx_done high for 3 cycles -> exactly one IDLE return, no extra pop.
REQ-040 SHALL cover this case: assert arst_n low during WAIT_DONE with 4 bytes queued -> all outputs at reset values immediately and empty=1.
